// File: rtl/sudoku_input_ctrl.sv
// Button front end for the sudoku board: synchronizes and debounces five buttons,
// then turns presses and held-direction auto-repeat into cursor moves and select strobes.
module sudoku_input_ctrl #(
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int REPEAT_DELAY    = 50000000,
    parameter int REPEAT_PERIOD   = 15000000
) (
    input  logic       clk,
    input  logic       clr,
    input  logic       btns,
    input  logic       btnu,
    input  logic       btnl,
    input  logic       btnd,
    input  logic       btnr,
    input  logic       enable,
    output logic [3:0] cur_row,
    output logic [3:0] cur_col,
    output logic       sel_pulse,
    output logic       move_pulse,
    output logic [4:0] btn_stable
);

    localparam int DW   = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int RMAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int HW   = $clog2(RMAX + 1);

    localparam logic [DW-1:0] DEB_LAST = DW'(DEBOUNCE_CYCLES - 1);
    localparam logic [HW-1:0] R_DELAY  = HW'(REPEAT_DELAY);
    localparam logic [HW-1:0] R_PERIOD = HW'(REPEAT_PERIOD);

    logic [4:0]    raw;
    logic [4:0]    sync1;
    logic [4:0]    sync2;
    logic [4:0]    stable_d;
    logic [DW-1:0] dcnt [5];
    logic [HW-1:0] hcnt [4];
    logic [3:0]    rep;

    logic [4:0] rise;
    logic [3:0] fire;
    logic [4:0] ev;
    logic [3:0] row_nxt;
    logic [3:0] col_nxt;

    assign raw  = {btnr, btnd, btnl, btnu, btns};
    assign rise = btn_stable & ~stable_d;

    // Hold counter reads k in the k-th cycle after the press event;
    // the first repeat waits REPEAT_DELAY, later ones REPEAT_PERIOD.
    always_comb begin
        fire = '0;
        for (int i = 0; i < 4; i++) begin
            fire[i] = btn_stable[i+1] &&
                      (hcnt[i] == (rep[i] ? R_PERIOD : R_DELAY));
        end
    end

    assign ev = {rise[4:1] | fire, rise[0]};

    always_comb begin
        row_nxt = cur_row;
        if (ev[1] && !ev[3]) begin
            row_nxt = (cur_row == 4'd0 || cur_row > 4'd8) ? 4'd8 : cur_row - 4'd1;
        end else if (ev[3] && !ev[1]) begin
            row_nxt = (cur_row >= 4'd8) ? 4'd0 : cur_row + 4'd1;
        end
    end

    always_comb begin
        col_nxt = cur_col;
        if (ev[2] && !ev[4]) begin
            col_nxt = (cur_col == 4'd0 || cur_col > 4'd8) ? 4'd8 : cur_col - 4'd1;
        end else if (ev[4] && !ev[2]) begin
            col_nxt = (cur_col >= 4'd8) ? 4'd0 : cur_col + 4'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (!clr) begin
            sync1      <= '0;
            sync2      <= '0;
            stable_d   <= '0;
            btn_stable <= '0;
            rep        <= '0;
            for (int i = 0; i < 5; i++) dcnt[i] <= '0;
            for (int i = 0; i < 4; i++) hcnt[i] <= '0;
            cur_row    <= 4'd4;
            cur_col    <= 4'd4;
            sel_pulse  <= 1'b0;
            move_pulse <= 1'b0;
        end else begin
            sync1    <= raw;
            sync2    <= sync1;
            stable_d <= btn_stable;

            for (int i = 0; i < 5; i++) begin
                if (sync2[i] == btn_stable[i]) begin
                    dcnt[i] <= '0;
                end else if (dcnt[i] == DEB_LAST) begin
                    dcnt[i]       <= '0;
                    btn_stable[i] <= ~btn_stable[i];
                end else begin
                    dcnt[i] <= dcnt[i] + 1'b1;
                end
            end

            // Runs regardless of enable so a re-enable keeps the schedule.
            for (int i = 0; i < 4; i++) begin
                if (!btn_stable[i+1]) begin
                    hcnt[i] <= '0;
                    rep[i]  <= 1'b0;
                end else if (fire[i]) begin
                    hcnt[i] <= HW'(1);
                    rep[i]  <= 1'b1;
                end else begin
                    hcnt[i] <= hcnt[i] + 1'b1;
                end
            end

            if (enable) begin
                cur_row    <= row_nxt;
                cur_col    <= col_nxt;
                sel_pulse  <= ev[0];
                move_pulse <= (row_nxt != cur_row) || (col_nxt != cur_col);
            end else begin
                sel_pulse  <= 1'b0;
                move_pulse <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_sudoku_input_ctrl.sv
// Directed bench for sudoku_input_ctrl with short debounce/repeat timing.
module tb_sudoku_input_ctrl;

    logic       clk = 1'b0;
    logic       clr = 1'b0;
    logic [4:0] b   = '0;
    logic       enable = 1'b1;
    logic [3:0] cur_row;
    logic [3:0] cur_col;
    logic       sel_pulse;
    logic       move_pulse;
    logic [4:0] btn_stable;

    int n_cmp = 0;
    int n_bad = 0;
    int mcnt  = 0;
    int scnt  = 0;
    int mbase;
    int sbase;

    sudoku_input_ctrl #(
        .DEBOUNCE_CYCLES(4),
        .REPEAT_DELAY   (20),
        .REPEAT_PERIOD  (8)
    ) dut (
        .clk       (clk),
        .clr       (clr),
        .btns      (b[0]),
        .btnu      (b[1]),
        .btnl      (b[2]),
        .btnd      (b[3]),
        .btnr      (b[4]),
        .enable    (enable),
        .cur_row   (cur_row),
        .cur_col   (cur_col),
        .sel_pulse (sel_pulse),
        .move_pulse(move_pulse),
        .btn_stable(btn_stable)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (move_pulse) mcnt++;
        if (sel_pulse)  scnt++;
    end

    task automatic check(input string tag, input int got, input int exp);
        n_cmp++;
        if (got != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        b      = '0;
        enable = 1'b1;
        clr    = 1'b0;
        step(3);
        clr    = 1'b1;
    endtask

    task automatic press(input int idx);
        b[idx] = 1'b1;
        step(7);
        b[idx] = 1'b0;
        step(8);
    endtask

    initial begin
        // Reset state, then a single right press
        do_reset();
        check("rst_row", cur_row, 4);
        check("rst_col", cur_col, 4);
        check("rst_stable", btn_stable, 0);
        check("rst_move", move_pulse, 0);
        check("rst_sel", sel_pulse, 0);
        mbase = mcnt;
        b[4] = 1'b1;
        step(5);
        check("r_stable_e5", btn_stable[4], 0);
        step(1);
        check("r_stable_e6", btn_stable[4], 1);
        check("r_move_e6", move_pulse, 0);
        step(1);
        check("r_move_e7", move_pulse, 1);
        check("r_col_e7", cur_col, 5);
        check("r_row_e7", cur_row, 4);
        step(3);
        b[4] = 1'b0;
        step(8);
        check("r_moves", mcnt - mbase, 1);
        check("r_col_end", cur_col, 5);

        // Short glitch on up
        do_reset();
        mbase = mcnt;
        b[1] = 1'b1;
        step(3);
        b[1] = 1'b0;
        step(10);
        check("g_stable", btn_stable, 0);
        check("g_moves", mcnt - mbase, 0);
        check("g_row", cur_row, 4);
        check("g_col", cur_col, 4);

        // Wraparound at both edges
        do_reset();
        mbase = mcnt;
        for (int i = 0; i < 4; i++) press(1);
        check("w_row0", cur_row, 0);
        press(1);
        check("w_row8", cur_row, 8);
        for (int i = 0; i < 4; i++) press(4);
        check("w_col8", cur_col, 8);
        press(4);
        check("w_col0", cur_col, 0);
        check("w_moves", mcnt - mbase, 10);

        // Held down with auto-repeat, select held alongside
        do_reset();
        mbase = mcnt;
        sbase = scnt;
        b[3] = 1'b1;
        b[0] = 1'b1;
        step(7);
        check("h_row_e7", cur_row, 5);
        check("h_move_e7", move_pulse, 1);
        check("h_sel_e7", sel_pulse, 1);
        step(19);
        check("h_row_e26", cur_row, 5);
        step(1);
        check("h_row_e27", cur_row, 6);
        check("h_move_e27", move_pulse, 1);
        step(8);
        check("h_row_e35", cur_row, 7);
        step(21);
        b[3] = 1'b0;
        b[0] = 1'b0;
        step(20);
        check("h_row_end", cur_row, 1);
        check("h_moves", mcnt - mbase, 6);
        check("h_sels", scnt - sbase, 1);
        check("h_stable", btn_stable, 0);

        // Left and right together cancel
        do_reset();
        mbase = mcnt;
        b[2] = 1'b1;
        b[4] = 1'b1;
        step(7);
        check("c_move", move_pulse, 0);
        check("c_col", cur_col, 4);
        b[2] = 1'b0;
        b[4] = 1'b0;
        step(10);
        check("c_moves", mcnt - mbase, 0);

        // Disabled press, then re-enable mid-hold
        do_reset();
        mbase = mcnt;
        enable = 1'b0;
        b[3] = 1'b1;
        step(7);
        check("d_stable3", btn_stable[3], 1);
        check("d_row", cur_row, 4);
        check("d_move", move_pulse, 0);
        step(23);
        check("d_moves", mcnt - mbase, 0);
        enable = 1'b1;
        step(4);
        check("d_row_e34", cur_row, 4);
        step(1);
        check("d_row_e35", cur_row, 5);
        b[3] = 1'b0;
        step(10);
        check("d_moves_end", mcnt - mbase, 1);

        // Reset in the middle of a select debounce
        do_reset();
        b[0] = 1'b1;
        step(4);
        clr = 1'b0;
        step(2);
        clr = 1'b1;
        sbase = scnt;
        step(6);
        check("x_sel_e6", sel_pulse, 0);
        check("x_sels_e6", scnt - sbase, 0);
        step(1);
        check("x_sel_e7", sel_pulse, 1);
        b[0] = 1'b0;
        step(10);
        check("x_sels", scnt - sbase, 1);
        check("x_row", cur_row, 4);
        check("x_col", cur_col, 4);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
